// File: rtl/fec_error_stats.sv
// fec_error_stats: FEC pre/post bit-error, frame-error and per-frame error histogram statistics
// Ports: clk, rst (async, active high); en/clear/target_frames run control;
//   in_valid/frame_last/lane_err_pre/lane_err_post sample input (lane i at [i*ERR_W +: ERR_W]);
//   busy/done status; total_bits/total_bit_errors_pre/total_bit_errors_post/total_frames/total_frame_errors
//   saturating counters; hist_rd_idx/hist_rd_data registered histogram read port.
// Build option: define FEC_STATS_HIST_EN to build the histogram; otherwise hist_rd_data is constant 0.
module fec_error_stats #(
  parameter int N_LANES   = 4,
  parameter int LANE_W    = 64,
  parameter int ERR_W     = 7,
  parameter int CNT_W     = 64,
  parameter int HIST_BINS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clear,
  input  logic [CNT_W-1:0]             target_frames,
  input  logic                         in_valid,
  input  logic                         frame_last,
  input  logic [N_LANES*ERR_W-1:0]     lane_err_pre,
  input  logic [N_LANES*ERR_W-1:0]     lane_err_post,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             total_bits,
  output logic [CNT_W-1:0]             total_bit_errors_pre,
  output logic [CNT_W-1:0]             total_bit_errors_post,
  output logic [CNT_W-1:0]             total_frames,
  output logic [CNT_W-1:0]             total_frame_errors,
  input  logic [$clog2(HIST_BINS)-1:0] hist_rd_idx,
  output logic [CNT_W-1:0]             hist_rd_data
);
  localparam int IDX_W = $clog2(HIST_BINS);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state;
  logic r_busy, r_done;
  logic [CNT_W-1:0] r_bits, r_pre, r_post, r_frames, r_ferr, r_acc;
  logic [CNT_W-1:0] w_pre_sum, w_post_sum, w_frame_tot, w_frames_nxt;
  logic w_acc, w_last;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // A lane can never report more errors than it carried bits, so each lane is clamped before summing.
  function automatic logic [CNT_W-1:0] clamp_sum(input logic [N_LANES*ERR_W-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < N_LANES; i++)
      s += (int'(v[i*ERR_W +: ERR_W]) > LANE_W) ? LANE_W : int'(v[i*ERR_W +: ERR_W]);
    return CNT_W'(s);
  endfunction

  assign w_acc        = (r_state == S_RUN) && in_valid;
  assign w_last       = w_acc && frame_last;
  assign w_pre_sum    = clamp_sum(lane_err_pre);
  assign w_post_sum   = clamp_sum(lane_err_post);
  assign w_frame_tot  = sat_add(r_acc, w_post_sum);
  assign w_frames_nxt = w_last ? sat_add(r_frames, CNT_W'(1)) : r_frames;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bits   <= '0;
      r_pre    <= '0;
      r_post   <= '0;
      r_frames <= '0;
      r_ferr   <= '0;
      r_acc    <= '0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bits   <= '0;
      r_pre    <= '0;
      r_post   <= '0;
      r_frames <= '0;
      r_ferr   <= '0;
      r_acc    <= '0;
    end else begin
      if (w_acc) begin
        r_bits <= sat_add(r_bits, CNT_W'(N_LANES * LANE_W));
        r_pre  <= sat_add(r_pre, w_pre_sum);
        r_post <= sat_add(r_post, w_post_sum);
        r_acc  <= frame_last ? '0 : w_frame_tot;
      end
      r_frames <= w_frames_nxt;
      r_ferr   <= (w_last && w_frame_tot != '0) ? sat_add(r_ferr, CNT_W'(1)) : r_ferr;
      case (r_state)
        S_IDLE: if (en) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
        S_RUN: if (target_frames != '0 && w_frames_nxt >= target_frames) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else if (!en) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_DONE: if (!en) begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign total_bits            = r_bits;
  assign total_bit_errors_pre  = r_pre;
  assign total_bit_errors_post = r_post;
  assign total_frames          = r_frames;
  assign total_frame_errors    = r_ferr;

`ifdef FEC_STATS_HIST_EN
  logic [CNT_W-1:0] r_hist [HIST_BINS];
  logic [CNT_W-1:0] r_hist_rd;
  logic [IDX_W-1:0] w_bin;
  logic [CNT_W-1:0] w_bin_nxt;

  // HIST_BINS is a power of two, so the top bin index is all-ones.
  assign w_bin     = (w_frame_tot >= CNT_W'(HIST_BINS - 1)) ? '1 : w_frame_tot[IDX_W-1:0];
  assign w_bin_nxt = sat_add(r_hist[w_bin], CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
      r_hist_rd <= '0;
    end else if (clear) begin
      for (int i = 0; i < HIST_BINS; i++) r_hist[i] <= '0;
      r_hist_rd <= '0;
    end else begin
      if (w_last) r_hist[w_bin] <= w_bin_nxt;
      // Forward a same-cycle update so the read returns the bin's new value.
      r_hist_rd <= (w_last && w_bin == hist_rd_idx) ? w_bin_nxt : r_hist[hist_rd_idx];
    end
  end

  assign hist_rd_data = r_hist_rd;
`else
  logic w_unused_idx;
  assign w_unused_idx = ^hist_rd_idx;
  assign hist_rd_data = '0;
`endif
endmodule

// File: doc/fec_error_stats.md
FEC_ERROR_STATS -- requirements
Module: fec_error_stats

Interface
REQ-001 SHALL have parameter N_LANES, default 4, parallel lanes per cycle.
REQ-002 SHALL have parameter LANE_W, default 64, bits per lane per cycle.
REQ-003 SHALL have parameter ERR_W, default 7, width of each per-lane error count.
REQ-004 SHALL have parameter CNT_W, default 64, width of every statistics counter.
REQ-005 SHALL have parameter HIST_BINS, default 16, power of two, number of per-frame error histogram bins.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports en (in, 1, run enable), clear (in, 1, synchronous counter clear) and target_frames (in, CNT_W, stop count; 0 = unlimited).
REQ-009 SHALL have ports in_valid (in, 1), frame_last (in, 1, final cycle of a frame), lane_err_pre and lane_err_post (in, N_LANES*ERR_W, lane i at bits [i*ERR_W +: ERR_W]).
REQ-010 SHALL have outputs busy (1), done (1), and total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors (CNT_W each).
REQ-011 SHALL have hist_rd_idx (in, log2(HIST_BINS)) and hist_rd_data (out, CNT_W).

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-013 IDLE->RUN when en=1; RUN->IDLE when en=0 (pause, all counters and partial frame held); RUN->DONE when target_frames!=0 and total_frames after update >= target_frames; DONE->IDLE on clear or en=0.
REQ-014 A sample SHALL be accepted only when state is RUN and in_valid=1; all other cycles leave counters unchanged.
REQ-015 Per accepted sample: total_bits += N_LANES*LANE_W; total_bit_errors_pre/post += sum over lanes of the lane count, each lane count clamped to LANE_W first.
REQ-016 A frame accumulator SHALL sum clamped post-FEC errors across accepted samples of the current frame.
REQ-017 On an accepted sample with frame_last=1: total_frames += 1; total_frame_errors += 1 if accumulator plus this sample's post errors > 0; histogram bin min(that total, HIST_BINS-1) += 1; accumulator reset to 0.
REQ-018 frame_last with in_valid=0 SHALL be ignored.
REQ-019 All counters and histogram bins SHALL saturate at all-ones, never wrap.
REQ-020 Counter outputs SHALL be registered, reflecting an accepted sample exactly one cycle after acceptance.
REQ-021 hist_rd_data SHALL be registered: value of bin hist_rd_idx one cycle after idx presented, including same-cycle updates.
REQ-022 clear=1 SHALL zero all counters, bins and accumulator, force IDLE, and override a same-cycle accepted sample.
REQ-023 Acceptance that reaches target_frames SHALL be counted; later samples in DONE are dropped.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, all counters, bins, accumulator and hist_rd_data to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; first frame after reset starts at accumulator 0.

Configuration
REQ-026 Macro FEC_STATS_HIST_EN: defined, histogram (REQ-017 bin update, REQ-021) is built; undefined, no bin storage exists, hist_rd_data is constant 0, all other behaviour identical.

Verification (N_LANES=4, LANE_W=64, HIST_BINS=16, macro defined)
REQ-027 rst, en=1, 10 valid samples all errors 0, frame_last every 5th -> total_bits=2560, total_frames=2, total_frame_errors=0, bin0=2.
REQ-028 One sample, lane_err_post lanes = {3,0,100,1}, frame_last=1 -> total_bit_errors_post=68 (100 clamped to 64), frame_errors=1, bin15=1.
REQ-029 target_frames=3, frame_last on every valid sample for 5 cycles -> total_frames=3, done=1, busy=0, further samples ignored.
REQ-030 Frame of 2 samples with post errors 2 then 0, en=0 between them for 4 cycles -> accumulator held, frame_errors=1, bin2=1.
REQ-031 clear=1 coincident with an accepted sample after total_bits=1024 -> next cycle all counters 0, state IDLE.
REQ-032 Preload total_bit_errors_pre to all-ones minus 10 via repeated samples (force), add sample with 64 errors -> counter = all-ones.
